// File: rtl/reg_rename_stage.sv
// Register-rename stage: speculative/committed map tables, free-register vector,
// physical busy bits and a one-entry valid/ready output register toward the queue.
module reg_rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PHYS_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs,
  input  logic [4:0]           in_rt,
  input  logic [4:0]           in_rw,
  input  logic                 in_uses_rs,
  input  logic                 in_uses_rt,
  input  logic                 in_uses_rw,
  input  logic [31:0]          in_instr_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PHYS_W-1:0]    out_rs_phys,
  output logic [PHYS_W-1:0]    out_rt_phys,
  output logic [PHYS_W-1:0]    out_rw_phys,
  output logic [PHYS_W-1:0]    out_old_rw_phys,
  output logic                 out_uses_rs,
  output logic                 out_uses_rt,
  output logic                 out_uses_rw,
  output logic [31:0]          out_instr_count,
  output logic [PHYS_REGS-1:0] busy_bits,
  input  logic                 wb_valid,
  input  logic [PHYS_W-1:0]    wb_phys,
  input  logic                 commit_valid,
  input  logic [4:0]           commit_rw_arch,
  input  logic [PHYS_W-1:0]    commit_rw_phys,
  input  logic [PHYS_W-1:0]    commit_old_phys,
  input  logic                 flush
);

  typedef logic [ARCH_REGS-1:0][PHYS_W-1:0] map_t;

  typedef struct packed {
    logic [PHYS_W-1:0] rs_phys;
    logic [PHYS_W-1:0] rt_phys;
    logic [PHYS_W-1:0] rw_phys;
    logic [PHYS_W-1:0] old_rw_phys;
    logic              uses_rs;
    logic              uses_rt;
    logic              uses_rw;
    logic [31:0]       instr_count;
  } out_t;

  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < ARCH_REGS; i++) m[i] = PHYS_W'(i);
    return m;
  endfunction

  localparam map_t RESET_MAP = identity_map();
  localparam logic [PHYS_REGS-1:0] RESET_FREE =
    {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  map_t                 spec_map_q, spec_map_d;
  map_t                 commit_map_q, commit_map_d;
  logic [PHYS_REGS-1:0] free_vec_q, free_vec_d;
  logic [PHYS_REGS-1:0] busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  out_t                 out_q, out_d;

  logic              need_alloc;
  logic              any_free;
  logic              fire;
  logic [PHYS_W-1:0] alloc_idx;

  always_comb begin
    need_alloc = in_uses_rw & (in_rw != 5'd0);
    any_free   = |free_vec_q;
    // Downward scan so the last hit is the lowest free index.
    alloc_idx  = '0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (free_vec_q[i]) alloc_idx = PHYS_W'(i);
    end
    in_ready = (~out_valid_q | out_ready) & (~need_alloc | any_free) & ~flush;
    fire     = in_valid & in_ready;

    spec_map_d   = spec_map_q;
    commit_map_d = commit_map_q;
    free_vec_d   = free_vec_q;
    busy_d       = busy_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;

    if (commit_valid) begin
      if (commit_rw_arch != 5'd0) commit_map_d[commit_rw_arch] = commit_rw_phys;
      if (commit_old_phys != '0) free_vec_d[commit_old_phys] = 1'b1;
    end

    if (flush) begin
      // Rebuild from the post-commit map so a same-cycle retire is kept.
      spec_map_d = commit_map_d;
      free_vec_d = '1;
      for (int i = 0; i < ARCH_REGS; i++) free_vec_d[commit_map_d[i]] = 1'b0;
      busy_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wb_valid && (wb_phys != '0)) busy_d[wb_phys] = 1'b0;
      if (fire) begin
        out_valid_d       = 1'b1;
        out_d.rs_phys     = in_uses_rs ? spec_map_q[in_rs] : '0;
        out_d.rt_phys     = in_uses_rt ? spec_map_q[in_rt] : '0;
        out_d.rw_phys     = need_alloc ? alloc_idx : '0;
        out_d.old_rw_phys = need_alloc ? spec_map_q[in_rw] : '0;
        out_d.uses_rs     = in_uses_rs;
        out_d.uses_rt     = in_uses_rt;
        out_d.uses_rw     = need_alloc;
        out_d.instr_count = in_instr_count;
        if (need_alloc) begin
          spec_map_d[in_rw]     = alloc_idx;
          free_vec_d[alloc_idx] = 1'b0;
          busy_d[alloc_idx]     = 1'b1;
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_map_q   <= RESET_MAP;
      commit_map_q <= RESET_MAP;
      free_vec_q   <= RESET_FREE;
      busy_q       <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      spec_map_q   <= spec_map_d;
      commit_map_q <= commit_map_d;
      free_vec_q   <= free_vec_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_rs_phys     = out_q.rs_phys;
  assign out_rt_phys     = out_q.rt_phys;
  assign out_rw_phys     = out_q.rw_phys;
  assign out_old_rw_phys = out_q.old_rw_phys;
  assign out_uses_rs     = out_q.uses_rs;
  assign out_uses_rt     = out_q.uses_rt;
  assign out_uses_rw     = out_q.uses_rw;
  assign out_instr_count = out_q.instr_count;
  assign busy_bits       = busy_q;

endmodule

// File: tb/tb_reg_rename_stage.sv
// Bench for reg_rename_stage: directed scenarios then random traffic, all checked
// against an array/queue model of rename, commit, writeback and flush.
module tb_reg_rename_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rw;
  logic        in_uses_rs, in_uses_rt, in_uses_rw;
  logic [31:0] in_instr_count;
  logic        out_valid, out_ready;
  logic [5:0]  out_rs_phys, out_rt_phys, out_rw_phys, out_old_rw_phys;
  logic        out_uses_rs, out_uses_rt, out_uses_rw;
  logic [31:0] out_instr_count;
  logic [63:0] busy_bits;
  logic        wb_valid;
  logic [5:0]  wb_phys;
  logic        commit_valid;
  logic [4:0]  commit_rw_arch;
  logic [5:0]  commit_rw_phys, commit_old_phys;
  logic        flush;

  always #5 clk = ~clk;

  reg_rename_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rw(in_rw),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_uses_rw(in_uses_rw),
    .in_instr_count(in_instr_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_phys(out_rs_phys), .out_rt_phys(out_rt_phys),
    .out_rw_phys(out_rw_phys), .out_old_rw_phys(out_old_rw_phys),
    .out_uses_rs(out_uses_rs), .out_uses_rt(out_uses_rt), .out_uses_rw(out_uses_rw),
    .out_instr_count(out_instr_count),
    .busy_bits(busy_bits),
    .wb_valid(wb_valid), .wb_phys(wb_phys),
    .commit_valid(commit_valid), .commit_rw_arch(commit_rw_arch),
    .commit_rw_phys(commit_rw_phys), .commit_old_phys(commit_old_phys),
    .flush(flush)
  );

  // Reference model state
  int sm[32];
  int cm[32];
  bit fr[64];
  bit bz[64];
  bit m_ov;
  int m_rs, m_rt, m_rw, m_old;
  bit m_urs, m_urt, m_urw;
  logic [31:0] m_cnt;

  typedef struct {int arch; int phys; int old;} rob_t;
  rob_t rob[$];

  int n_cmp = 0;
  int n_err = 0;
  int seq   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 64; i++) if (fr[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin sm[i] = i; cm[i] = i; end
    for (int i = 0; i < 64; i++) begin fr[i] = (i >= 32); bz[i] = 1'b0; end
    m_ov = 0; m_rs = 0; m_rt = 0; m_rw = 0; m_old = 0;
    m_urs = 0; m_urt = 0; m_urw = 0; m_cnt = '0;
    rob.delete();
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_rs = '0; in_rt = '0; in_rw = '0;
    in_uses_rs = 0; in_uses_rt = 0; in_uses_rw = 0; in_instr_count = '0;
    out_ready = 1; wb_valid = 0; wb_phys = '0;
    commit_valid = 0; commit_rw_arch = '0; commit_rw_phys = '0; commit_old_phys = '0;
    flush = 0;
  endtask

  task automatic set_instr(input int rs, input int rt, input int rw,
                           input bit urs, input bit urt, input bit urw);
    clear_inputs();
    seq++;
    in_valid = 1; in_rs = 5'(rs); in_rt = 5'(rt); in_rw = 5'(rw);
    in_uses_rs = urs; in_uses_rt = urt; in_uses_rw = urw;
    in_instr_count = 32'(seq);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // Called at a falling edge with inputs applied; checks, then advances one cycle.
  task automatic step();
    logic [63:0] bexp;
    int nf, old_map;
    bit need, rdy, fire;
    #1;
    need = in_uses_rw && (in_rw != 0);
    nf   = lowest_free();
    rdy  = (!m_ov || out_ready) && (!need || nf >= 0) && !flush;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_rs_phys", out_rs_phys, m_rs);
      chk("out_rt_phys", out_rt_phys, m_rt);
      chk("out_rw_phys", out_rw_phys, m_rw);
      chk("out_old_rw_phys", out_old_rw_phys, m_old);
      chk("out_uses", {out_uses_rs, out_uses_rt, out_uses_rw}, {m_urs, m_urt, m_urw});
      chk("out_instr_count", out_instr_count, m_cnt);
    end
    for (int i = 0; i < 64; i++) bexp[i] = bz[i];
    chk("busy_bits", busy_bits, bexp);
    @(posedge clk);
    fire = in_valid && rdy;
    if (commit_valid) begin
      cm[commit_rw_arch] = int'(commit_rw_phys);
      if (commit_old_phys != 0) fr[commit_old_phys] = 1;
      if (rob.size() > 0) void'(rob.pop_front());
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) sm[i] = cm[i];
      for (int i = 0; i < 64; i++) begin fr[i] = 1; bz[i] = 0; end
      for (int i = 0; i < 32; i++) fr[cm[i]] = 0;
      m_ov = 0;
      rob.delete();
    end else begin
      if (wb_valid && wb_phys != 0) bz[wb_phys] = 0;
      if (fire) begin
        old_map = sm[in_rw];
        m_ov  = 1;
        m_rs  = in_uses_rs ? sm[in_rs] : 0;
        m_rt  = in_uses_rt ? sm[in_rt] : 0;
        m_rw  = need ? nf : 0;
        m_old = need ? old_map : 0;
        m_urs = in_uses_rs; m_urt = in_uses_rt; m_urw = need;
        m_cnt = in_instr_count;
        if (need) begin
          sm[in_rw] = nf; fr[nf] = 0; bz[nf] = 1;
          rob.push_back('{int'(in_rw), nf, old_map});
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    int cand[$];
    clear_inputs();
    seq++;
    in_valid   = ($urandom_range(9) < 7);
    in_rs      = 5'($urandom_range(31));
    in_rt      = 5'($urandom_range(31));
    in_rw      = 5'($urandom_range(31));
    in_uses_rs = ($urandom_range(3) != 0);
    in_uses_rt = ($urandom_range(3) != 0);
    in_uses_rw = ($urandom_range(4) != 0);
    in_instr_count = $urandom;
    out_ready  = ($urandom_range(3) != 0);
    for (int i = 1; i < 64; i++) if (bz[i]) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(1) == 1) begin
      wb_valid = 1;
      wb_phys  = 6'(cand[$urandom_range(cand.size() - 1)]);
    end
    if (rob.size() > 0 && $urandom_range(9) < 4) begin
      commit_valid    = 1;
      commit_rw_arch  = 5'(rob[0].arch);
      commit_rw_phys  = 6'(rob[0].phys);
      commit_old_phys = 6'(rob[0].old);
    end
    flush = ($urandom_range(99) < 3);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Reset state
    #1;
    chk("rst_out_rs", out_rs_phys, 0);
    chk("rst_out_rw", out_rw_phys, 0);
    chk("rst_out_cnt", out_instr_count, 0);
    step();

    // add r3 <- r1, r2
    set_instr(1, 2, 3, 1, 1, 1); step(); clear_inputs(); #1;
    chk("t1_rs", out_rs_phys, 1);
    chk("t1_rt", out_rt_phys, 2);
    chk("t1_rw", out_rw_phys, 32);
    chk("t1_old", out_old_rw_phys, 3);
    chk("t1_busy32", busy_bits[32], 1);
    step();

    // r5 <- r5, r5 twice, then writeback of 32
    do_reset();
    set_instr(5, 5, 5, 1, 1, 1); step(); #1;
    chk("t2a_rs", out_rs_phys, 5);
    chk("t2a_rw", out_rw_phys, 32);
    set_instr(5, 5, 5, 1, 1, 1); step(); #1;
    chk("t2b_rs", out_rs_phys, 32);
    chk("t2b_rw", out_rw_phys, 33);
    chk("t2b_old", out_old_rw_phys, 32);
    clear_inputs(); wb_valid = 1; wb_phys = 6'd32; step(); clear_inputs(); #1;
    chk("t2_busy", {busy_bits[33], busy_bits[32]}, 2'b10);

    // Exhaust the free list, then free phys 7 by commit
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_instr(0, 0, ((i + 6) % 31) + 1, 0, 0, 1);
      step();
    end
    set_instr(0, 0, 20, 0, 0, 1); #1;
    chk("t3_full_ready", in_ready, 0);
    step();
    commit_valid = 1; commit_rw_arch = 5'd7; commit_rw_phys = 6'd32; commit_old_phys = 6'd7;
    step();
    commit_valid = 0; step(); clear_inputs(); #1;
    chk("t3_realloc", out_rw_phys, 7);
    step();

    // Output backpressure for three cycles
    do_reset();
    set_instr(1, 2, 3, 1, 1, 1); step();
    set_instr(4, 5, 6, 1, 1, 1); out_ready = 0;
    repeat (3) step();
    #1;
    chk("t4_stall_rw", out_rw_phys, 32);
    out_ready = 1; step(); clear_inputs(); #1;
    chk("t4_next_rw", out_rw_phys, 33);
    step();

    // Two renames of r4, commit the first together with flush
    do_reset();
    set_instr(0, 0, 4, 0, 0, 1); step();
    set_instr(0, 0, 4, 0, 0, 1); step();
    clear_inputs();
    commit_valid = 1; commit_rw_arch = 5'd4; commit_rw_phys = 6'd32; commit_old_phys = 6'd4;
    flush = 1;
    step(); clear_inputs(); #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy_bits, 64'd0);
    set_instr(4, 0, 9, 1, 0, 1); step(); #1;
    chk("t5_map4", out_rs_phys, 32);
    chk("t5_free4", out_rw_phys, 4);
    set_instr(0, 0, 10, 0, 0, 1); step(); #1;
    chk("t5_free33", out_rw_phys, 33);

    // Destination r0 never allocates
    set_instr(0, 0, 0, 0, 0, 1); step(); #1;
    chk("t6_uses_rw", out_uses_rw, 0);
    chk("t6_rw", out_rw_phys, 0);
    set_instr(0, 0, 11, 0, 0, 1); step(); #1;
    chk("t6_next_alloc", out_rw_phys, 34);

    // Random traffic
    do_reset();
    repeat (3000) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
